// File: rtl/hb_decim_mc.sv
// hb_decim_mc: multi-channel halfband decimate-by-2 FIR.
// Every channel keeps its own NUM_TAPS-deep delay line and a phase bit. Every
// second accepted sample of a channel starts a serial multiply-accumulate over
// the symmetric tap pairs. The result is rounded half up, saturated and
// strobed out together with its channel tag. In bypass mode the accepted
// input is forwarded one cycle later and no decimation takes place.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      synchronous active-low reset
//   bypass       1 = pass input straight through (sampled at accept)
//   x_in         input sample, signed DATA_W
//   x_in_ch      channel tag of x_in
//   x_in_valid   one-cycle input strobe
//   x_in_ready   high when a sample can be accepted this cycle
//   y_out        output sample, held between strobes
//   y_out_ch     channel tag of y_out
//   y_out_valid  one-cycle output strobe
//   overrun      sticky: a valid sample arrived while not ready
module hb_decim_mc #(
  parameter int DATA_W   = 16,
  parameter int NUM_TAPS = 11,
  parameter int COEF_W   = 18,
  // Packed unique non-center taps; slice j (LSB first) is h[2j], so slice 0
  // is the outermost tap. Default is {39322, -8192, 1638}.
  parameter logic [((NUM_TAPS+1)/4)*COEF_W-1:0] COEFS = {18'd39322, 18'h3E000, 18'd1638},
  parameter int NUM_CH   = 2,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     bypass,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic [CH_W-1:0]          x_in_ch,
  input  logic                     x_in_valid,
  output logic                     x_in_ready,
  output logic signed [DATA_W-1:0] y_out,
  output logic [CH_W-1:0]          y_out_ch,
  output logic                     y_out_valid,
  output logic                     overrun
);

  localparam int M     = (NUM_TAPS + 1) / 4;
  localparam int C     = (NUM_TAPS - 1) / 2;
  localparam int ACC_W = DATA_W + COEF_W + $clog2(M) + 2;
  localparam int MC_W  = (M > 1) ? $clog2(M) : 1;

  localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);
  localparam logic signed [ACC_W-1:0] RND   = {{(ACC_W-COEF_W+1){1'b0}}, 1'b1, {(COEF_W-2){1'b0}}};
  localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                     state, state_nxt;
  logic                       run;
  logic signed [DATA_W-1:0]   line [NUM_CH][NUM_TAPS];
  logic [NUM_CH-1:0]          phase;
  logic [CH_W-1:0]            ch_q;
  logic [MC_W-1:0]            mac_cnt;
  logic signed [ACC_W-1:0]    acc;

  logic                       ch_ok, accept, start;
  logic signed [DATA_W-1:0]   tap_a, tap_b;
  logic signed [COEF_W-1:0]   coef;
  logic signed [DATA_W:0]     pre;
  logic signed [DATA_W+COEF_W:0] prod;
  logic signed [ACC_W-1:0]    center, acc_base, acc_sum, rnd_shift;
  logic signed [DATA_W-1:0]   y_sat;

  assign x_in_ready = run && (state == IDLE);
  assign ch_ok      = {1'b0, x_in_ch} < NUM_CH_L;
  assign accept     = x_in_valid && x_in_ready && ch_ok;
  assign start      = accept && !bypass && phase[x_in_ch];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = MAC;
      MAC:     if (mac_cnt == MC_W'(M-1)) state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tap_a = '0;
    tap_b = '0;
    coef  = '0;
    for (int unsigned j = 0; j < M; j++) begin
      if (mac_cnt == MC_W'(j)) begin
        tap_a = line[ch_q][2*j];
        tap_b = line[ch_q][NUM_TAPS-1-2*j];
        coef  = COEFS[j*COEF_W +: COEF_W];
      end
    end
    pre    = {tap_a[DATA_W-1], tap_a} + {tap_b[DATA_W-1], tap_b};
    prod   = pre * coef;
    center = ACC_W'(line[ch_q][C]) <<< (COEF_W-2);
    // The center term is folded into the first MAC step instead of being
    // loaded at the accept edge; the delay line is stable by then.
    acc_base  = (mac_cnt == '0) ? center : acc;
    acc_sum   = acc_base + ACC_W'(prod);
    rnd_shift = (acc + RND) >>> (COEF_W-1);
    if (rnd_shift > Y_MAX)      y_sat = Y_MAX[DATA_W-1:0];
    else if (rnd_shift < Y_MIN) y_sat = Y_MIN[DATA_W-1:0];
    else                        y_sat = rnd_shift[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      run         <= 1'b0;
      phase       <= '0;
      ch_q        <= '0;
      mac_cnt     <= '0;
      acc         <= '0;
      y_out       <= '0;
      y_out_ch    <= '0;
      y_out_valid <= 1'b0;
      overrun     <= 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++)
        for (int unsigned k = 0; k < NUM_TAPS; k++)
          line[c][k] <= '0;
    end else begin
      run         <= 1'b1;
      state       <= state_nxt;
      y_out_valid <= 1'b0;
      if (x_in_valid && !x_in_ready && ch_ok) overrun <= 1'b1;
      if (accept) begin
        line[x_in_ch][0] <= x_in;
        for (int unsigned k = 1; k < NUM_TAPS; k++)
          line[x_in_ch][k] <= line[x_in_ch][k-1];
        phase[x_in_ch] <= ~phase[x_in_ch];
        if (bypass) begin
          y_out       <= x_in;
          y_out_ch    <= x_in_ch;
          y_out_valid <= 1'b1;
        end else if (phase[x_in_ch]) begin
          ch_q    <= x_in_ch;
          mac_cnt <= '0;
        end
      end
      case (state)
        MAC: begin
          acc     <= acc_sum;
          mac_cnt <= mac_cnt + 1'b1;
        end
        OUT: begin
          y_out       <= y_sat;
          y_out_ch    <= ch_q;
          y_out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
